muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/HI/LO width in bits.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_b  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request pulse, sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port a  input  WIDTH  rs operand (multiplicand/dividend), sampled with start.
REQ-007 SHALL have port b  input  WIDTH  rt operand (multiplier/divisor), sampled with start.
REQ-008 SHALL have port flush  input  1  abort current operation.
REQ-009 SHALL have port busy  output  1  operation in progress; pipeline stalls HI/LO readers on it.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err  output  1  last op was divide-by-zero or unsupported; held until next accepted start.
REQ-012 SHALL have ports hi and lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, FIXUP, DONE.
REQ-014 SHALL, in IDLE with start=1 and flush=0 (cycle 0), latch |a|,|b| (signed ops) or a,b (unsigned ops) and record result sign flags, clear err, enter MUL or DIV.
REQ-015 SHALL iterate exactly WIDTH cycles in MUL (shift-add, 2*WIDTH-bit accumulator) and in DIV (restoring, one quotient bit per cycle), then spend one cycle in FIXUP.
REQ-016 SHALL in FIXUP negate the 2*WIDTH product if operand signs differ (MULT), negate quotient if signs differ and give remainder the dividend's sign (DIV); unsigned ops pass through.
REQ-017 SHALL load hi (product upper/remainder) and lo (product lower/quotient) on the FIXUP->DONE edge; done=1 for exactly the DONE cycle, cycle WIDTH+2 after start.
REQ-018 SHALL assert busy in MUL, DIV, FIXUP (cycles 1..WIDTH+1); busy=0 in IDLE and DONE.
REQ-019 SHALL ignore start when not in IDLE; DONE returns to IDLE next cycle, so next start accepted at cycle WIDTH+3.
REQ-020 SHALL, for DIV/DIVU with b=0, skip iteration: go IDLE->DONE, done at cycle 1, err=1, hi/lo unchanged.
REQ-021 SHALL produce for DIV of most-negative by -1: lo=most-negative, hi=0, err=0.
REQ-022 SHALL on flush=1 in any state return to IDLE next edge, no done, hi/lo unchanged, err unchanged; flush wins over simultaneous start.
REQ-023 SHALL never change hi/lo except on the FIXUP->DONE edge.

Reset
REQ-024 SHALL on rst_b=0, immediately and independent of clk, force IDLE, busy=0, done=0, err=0, hi=0, lo=0, internal accumulators 0.
REQ-025 SHALL abort any in-flight operation on reset with no done pulse after release; first start accepted on first rising edge with rst_b=1.

Configuration
REQ-026 SHALL, with MULDIV_DIV_EN defined, include the divider datapath and DIV state per REQ-015..021.
REQ-027 SHALL, without MULDIV_DIV_EN, omit divider logic and DIV state; DIV/DIVU requests go IDLE->DONE, done at cycle 1, err=1, hi/lo unchanged; MULT/MULTU unaffected.

Verification
REQ-028 SHALL cover MULT a=7 b=0xFFFFFFFD -> busy cycles 1..33, done at cycle 34, hi=0xFFFFFFFF lo=0xFFFFFFEB, err=0.
REQ-029 SHALL cover MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001 at cycle 34.
REQ-030 SHALL cover DIV a=0xFFFFFFF9 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; and DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
REQ-031 SHALL cover DIVU a=5 b=0 after prior result -> done at cycle 1, err=1, hi/lo retain prior values; both macro settings for DIV a=9 b=2 (lo=4 hi=1 vs err=1).
REQ-032 SHALL cover flush at cycle 10 of MULT -> busy=0 cycle 11, no done, hi/lo unchanged; start with flush same cycle -> not accepted.
REQ-033 SHALL cover rst_b low at cycle 20 of DIV -> immediate zero outputs, no done after release, start while busy ignored.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO pair.
// Shift-add multiply and restoring divide, WIDTH iterations each plus one sign-fixup cycle.
// Optional divider datapath and DIV state enabled by defining MULDIV_DIV_EN; without it,
// DIV/DIVU requests complete immediately with err set.

module muldiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned AccW = 2 * WIDTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
`ifdef MULDIV_DIV_EN
    DIV   = 3'd2,
`endif
    FIXUP = 3'd3,
    DONE  = 3'd4
  } stateT;

  stateT              state;
  logic [AccW-1:0]    acc;
  logic [WIDTH-1:0]   opB;
  logic [CntW-1:0]    cnt;
  logic               negRes;

  logic               opSigned;
  logic               aNeg;
  logic               bNeg;
  logic [WIDTH-1:0]   aAbs;
  logic [WIDTH-1:0]   bAbs;
  logic [WIDTH:0]     mulSum;
  logic [AccW-1:0]    mulNext;
  logic [AccW-1:0]    prodFix;

`ifdef MULDIV_DIV_EN
  logic               isDiv;
  logic               negRem;
  logic [WIDTH:0]     remTrial;
  logic               qBit;
  logic [WIDTH-1:0]   remNext;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;
`endif

  // Operand magnitudes, one multiply/divide step, and final sign correction
  always_comb begin
    opSigned = ~op[0];
    aNeg     = opSigned & a[WIDTH-1];
    bNeg     = opSigned & b[WIDTH-1];
    aAbs     = aNeg ? -a : a;
    bAbs     = bNeg ? -b : b;
    // carry out of the upper half lands in the top bit after the right shift
    mulSum   = {1'b0, acc[AccW-1:WIDTH]} + {1'b0, opB};
    mulNext  = acc[0] ? {mulSum, acc[WIDTH-1:1]} : {1'b0, acc[AccW-1:1]};
    prodFix  = negRes ? -acc : acc;
`ifdef MULDIV_DIV_EN
    // acc = {remainder, dividend/quotient}; trial-subtract the shifted-in remainder
    remTrial = acc[AccW-1:WIDTH-1] - {1'b0, opB};
    qBit     = ~remTrial[WIDTH];
    remNext  = qBit ? remTrial[WIDTH-1:0] : acc[AccW-2:WIDTH-1];
    quotFix  = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    remFix   = negRem ? -acc[AccW-1:WIDTH] : acc[AccW-1:WIDTH];
`endif
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      opB    <= '0;
      cnt    <= '0;
      negRes <= 1'b0;
`ifdef MULDIV_DIV_EN
      isDiv  <= 1'b0;
      negRem <= 1'b0;
`endif
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (op[1]) begin
`ifdef MULDIV_DIV_EN
              if (b == WIDTH'(0)) begin
                state <= DONE;
                done  <= 1'b1;
                err   <= 1'b1;
              end else begin
                state  <= DIV;
                busy   <= 1'b1;
                err    <= 1'b0;
                acc    <= {{WIDTH{1'b0}}, aAbs};
                opB    <= bAbs;
                cnt    <= '0;
                isDiv  <= 1'b1;
                negRes <= aNeg ^ bNeg;
                negRem <= aNeg;
              end
`else
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
`endif
            end else begin
              state  <= MUL;
              busy   <= 1'b1;
              err    <= 1'b0;
              acc    <= {{WIDTH{1'b0}}, bAbs};
              opB    <= aAbs;
              cnt    <= '0;
              negRes <= aNeg ^ bNeg;
`ifdef MULDIV_DIV_EN
              isDiv  <= 1'b0;
              negRem <= 1'b0;
`endif
            end
          end
        end
        MUL: begin
          acc <= mulNext;
          cnt <= cnt + CntW'(1);
          if (cnt == CntW'(WIDTH - 1)) state <= FIXUP;
        end
`ifdef MULDIV_DIV_EN
        DIV: begin
          acc <= {remNext, acc[WIDTH-2:0], qBit};
          cnt <= cnt + CntW'(1);
          if (cnt == CntW'(WIDTH - 1)) state <= FIXUP;
        end
`endif
        FIXUP: begin
`ifdef MULDIV_DIV_EN
          if (isDiv) begin
            hi <= remFix;
            lo <= quotFix;
          end else begin
            hi <= prodFix[AccW-1:WIDTH];
            lo <= prodFix[WIDTH-1:0];
          end
`else
          hi <= prodFix[AccW-1:WIDTH];
          lo <= prodFix[WIDTH-1:0];
`endif
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vectors for muldiv_ctrl (WIDTH=32); expectations adapt to MULDIV_DIV_EN.

module tb_muldiv_ctrl;

  localparam int unsigned W = 32;
`ifdef MULDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic         clk;
  logic         rstB;
  logic         startIn;
  logic [1:0]   opIn;
  logic [W-1:0] aIn;
  logic [W-1:0] bIn;
  logic         flushIn;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int           nChecks;
  int           nFails;
  logic [W-1:0] curHi;
  logic [W-1:0] curLo;
  int           doneCyc;
  int           busyCnt;
  int           doneCnt;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_b (rstB),
    .start (startIn),
    .op    (opIn),
    .a     (aIn),
    .b     (bIn),
    .flush (flushIn),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .hi    (hi),
    .lo    (lo)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    opIn    = op;
    aIn     = a;
    bIn     = b;
    startIn = 1'b1;
    tick();
    startIn = 1'b0;
  endtask

  // Observe cycles 1..nCyc after a start edge; optionally pulse a second start at pokeCyc
  task automatic watch(input int nCyc, input int pokeCyc, input logic [1:0] pOp,
                       input logic [W-1:0] pA, input logic [W-1:0] pB,
                       output int dCyc, output int bCnt, output int dCnt);
    dCyc = 0;
    bCnt = 0;
    dCnt = 0;
    for (int cyc = 1; cyc <= nCyc; cyc++) begin
      if (busy) bCnt++;
      if (done) begin
        dCnt++;
        if (dCyc == 0) dCyc = cyc;
      end
      startIn = (cyc == pokeCyc);
      if (cyc == pokeCyc) begin
        opIn = pOp;
        aIn  = pA;
        bIn  = pB;
      end
      tick();
    end
    startIn = 1'b0;
  endtask

  // Run one operation and check timing, flags and HI/LO against the expected result
  task automatic doOp(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] eHi, input logic [W-1:0] eLo);
    bit errExp;
    errExp = op[1] && (!DivEn || (b == 32'd0));
    issue(op, a, b);
    watch(40, 0, 2'b00, 32'd0, 32'd0, doneCyc, busyCnt, doneCnt);
    checkVal({tag, "_doneCnt"}, 64'(doneCnt), 64'd1);
    if (errExp) begin
      checkVal({tag, "_doneCyc"}, 64'(doneCyc), 64'd1);
      checkVal({tag, "_busyCnt"}, 64'(busyCnt), 64'd0);
      checkVal({tag, "_err"}, 64'(err), 64'd1);
      checkVal({tag, "_hi"}, 64'(hi), 64'(curHi));
      checkVal({tag, "_lo"}, 64'(lo), 64'(curLo));
    end else begin
      checkVal({tag, "_doneCyc"}, 64'(doneCyc), 64'd34);
      checkVal({tag, "_busyCnt"}, 64'(busyCnt), 64'd33);
      checkVal({tag, "_err"}, 64'(err), 64'd0);
      checkVal({tag, "_hi"}, 64'(hi), 64'(eHi));
      checkVal({tag, "_lo"}, 64'(lo), 64'(eLo));
      curHi = eHi;
      curLo = eLo;
    end
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    curHi   = '0;
    curLo   = '0;
    rstB    = 1'b0;
    startIn = 1'b0;
    flushIn = 1'b0;
    opIn    = 2'b00;
    aIn     = '0;
    bIn     = '0;

    repeat (2) tick();
    checkVal("rst_busy", 64'(busy), 64'd0);
    checkVal("rst_done", 64'(done), 64'd0);
    checkVal("rst_err", 64'(err), 64'd0);
    checkVal("rst_hi", 64'(hi), 64'd0);
    checkVal("rst_lo", 64'(lo), 64'd0);
    rstB = 1'b1;
    tick();

    doOp("mult_7_m3",     2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    doOp("multu_max",     2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    doOp("mult_minneg_1", 2'b00, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000);
    doOp("mult_m2_m3",    2'b00, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006);
    doOp("div_m7_2",      2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    doOp("div_7_m2",      2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    doOp("divu_big_2",    2'b11, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC);
    doOp("div_minneg_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    doOp("div_9_2",       2'b10, 32'h00000009, 32'h00000002, 32'h00000001, 32'h00000004);
    doOp("divu_5_0",      2'b11, 32'h00000005, 32'h00000000, 32'h0,        32'h0);

    // second start while busy must be ignored
    issue(2'b01, 32'd6, 32'd7);
    watch(40, 5, 2'b01, 32'd2, 32'd3, doneCyc, busyCnt, doneCnt);
    checkVal("poke_doneCyc", 64'(doneCyc), 64'd34);
    checkVal("poke_doneCnt", 64'(doneCnt), 64'd1);
    checkVal("poke_hi", 64'(hi), 64'd0);
    checkVal("poke_lo", 64'(lo), 64'd42);
    curHi = 32'd0;
    curLo = 32'd42;

    // flush at cycle 10 of MULT
    issue(2'b00, 32'd7, 32'd3);
    repeat (9) tick();
    flushIn = 1'b1;
    tick();
    flushIn = 1'b0;
    checkVal("flush_busy11", 64'(busy), 64'd0);
    checkVal("flush_done11", 64'(done), 64'd0);
    watch(40, 0, 2'b00, 32'd0, 32'd0, doneCyc, busyCnt, doneCnt);
    checkVal("flush_doneCnt", 64'(doneCnt), 64'd0);
    checkVal("flush_busyCnt", 64'(busyCnt), 64'd0);
    checkVal("flush_hi", 64'(hi), 64'(curHi));
    checkVal("flush_lo", 64'(lo), 64'(curLo));
    checkVal("flush_err", 64'(err), 64'd0);

    // start and flush together: start not accepted
    opIn    = 2'b01;
    aIn     = 32'd2;
    bIn     = 32'd2;
    startIn = 1'b1;
    flushIn = 1'b1;
    tick();
    startIn = 1'b0;
    flushIn = 1'b0;
    checkVal("sflush_busy", 64'(busy), 64'd0);
    watch(40, 0, 2'b00, 32'd0, 32'd0, doneCyc, busyCnt, doneCnt);
    checkVal("sflush_doneCnt", 64'(doneCnt), 64'd0);
    checkVal("sflush_busyCnt", 64'(busyCnt), 64'd0);
    checkVal("sflush_lo", 64'(lo), 64'(curLo));

    // asynchronous reset at cycle 20 of a long operation
    issue(DivEn ? 2'b10 : 2'b00, 32'd100, 32'd7);
    repeat (19) tick();
    checkVal("mid_busy20", 64'(busy), 64'd1);
    #2 rstB = 1'b0;
    #1;
    checkVal("arst_busy", 64'(busy), 64'd0);
    checkVal("arst_done", 64'(done), 64'd0);
    checkVal("arst_err", 64'(err), 64'd0);
    checkVal("arst_hi", 64'(hi), 64'd0);
    checkVal("arst_lo", 64'(lo), 64'd0);
    #2 rstB = 1'b1;
    opIn    = 2'b01;
    aIn     = 32'd3;
    bIn     = 32'd5;
    startIn = 1'b1;
    tick();
    startIn = 1'b0;
    watch(40, 0, 2'b00, 32'd0, 32'd0, doneCyc, busyCnt, doneCnt);
    checkVal("post_doneCyc", 64'(doneCyc), 64'd34);
    checkVal("post_doneCnt", 64'(doneCnt), 64'd1);
    checkVal("post_hi", 64'(hi), 64'd0);
    checkVal("post_lo", 64'(lo), 64'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
